// File: rtl/sram_dump_ctrl.sv
// SRAM readback engine: walks an inclusive address range and pushes each word
// into the outbound dump FIFO, stalling on FIFO backpressure.
module sram_dump_ctrl #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     control_mem_clk_i,
  input  logic                     control_mem_rst_i,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] last_addr_i,
  input  logic [DATA_WIDTH-1:0]    sram_dataout_i,
  input  logic                     fifo_full_i,
  output logic [ADDRESS_WIDTH-1:0] sram_address_o,
  output logic                     sram_cs_o,
  output logic                     sram_we_o,
  output logic [DATA_WIDTH-1:0]    fifo_datain_o,
  output logic                     write_fifo_o,
  output logic                     busy_o,
  output logic                     flag_readfinish_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] PUSH    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]               state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] last_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     cs_q;

  always_ff @(posedge control_mem_clk_i or posedge control_mem_rst_i) begin
    if (control_mem_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
    end else begin
      // Chip select is registered so the SRAM sees a clean one-cycle low pulse.
      cs_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q  <= base_addr_i;
            last_q  <= last_addr_i;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cs_q    <= 1'b0;
          state_q <= READ;
        end
        READ: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          data_q  <= sram_dataout_i;
          state_q <= PUSH;
        end
        PUSH: begin
          // The address moves only here, so it stays stable for the whole word.
          if (!fifo_full_i) begin
            if (addr_q == last_q) begin
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q + ADDRESS_WIDTH'(1);
              state_q <= SETUP;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sram_address_o    = addr_q;
  assign sram_cs_o         = cs_q;
  assign sram_we_o         = 1'b1;
  assign fifo_datain_o     = data_q;
  assign write_fifo_o      = (state_q == PUSH) && !fifo_full_i;
  assign busy_o            = (state_q != IDLE);
  assign flag_readfinish_o = (state_q == DONE);

endmodule

// File: tb/tb_sram_dump_ctrl.sv
// Bench for sram_dump_ctrl: directed plan scenarios plus randomized dumps,
// checked cycle by cycle against a push-scheduling reference model.
module tb_sram_dump_ctrl;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_a = '0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] dout = '0;
  logic          full = 1'b0;
  logic [AW-1:0] addr;
  logic          cs, we, wr, busy, fin;
  logic [DW-1:0] din;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] key  = 32'hA5A5_0000;
  logic [31:0] mulc = 32'd1;

  sram_dump_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .control_mem_clk_i (clk),
    .control_mem_rst_i (rst),
    .start_i           (start),
    .base_addr_i       (base_a),
    .last_addr_i       (last_a),
    .sram_dataout_i    (dout),
    .fifo_full_i       (full),
    .sram_address_o    (addr),
    .sram_cs_o         (cs),
    .sram_we_o         (we),
    .fifo_datain_o     (din),
    .write_fifo_o      (wr),
    .busy_o            (busy),
    .flag_readfinish_o (fin)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return ({19'b0, a} * mulc) ^ key;
  endfunction

  // Synchronous-read SRAM; junk on the bus when not selected.
  always @(posedge clk) begin
    if (!cs) dout <= memf(addr);
    else     dout <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_addr"}, addr, 0);
    check_eq({tag, "_cs"}, cs, 1);
    check_eq({tag, "_we"}, we, 1);
    check_eq({tag, "_data"}, din, 0);
    check_eq({tag, "_wr"}, wr, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_fin"}, fin, 0);
  endtask

  // Model: word k may be pushed on the first not-full cycle at or after ready;
  // after a push at cycle t the next word is ready at t+4.
  task automatic run_dump(input logic [AW-1:0] b, input logic [AW-1:0] l, input int pct,
                          input int fs, input int fl, input int ign_t, input int rst_t,
                          output int done_o);
    logic [AW-1:0] diff, ea;
    int n, k, ready, done_t, t, dut_pushes;
    logic exp_w;
    diff = l - b;
    n = int'(diff) + 1;
    k = 0; ready = 3; done_t = 1 << 30; t = 0; dut_pushes = 0;
    @(negedge clk);
    start = 1'b1; base_a = b; last_a = l; full = 1'b0;
    #1;
    check_eq("pre_busy", busy, 0);
    @(posedge clk);
    while (t <= done_t + 1) begin
      if (t > 5000) begin
        check_eq("timeout", t, 5000);
        break;
      end
      @(negedge clk);
      start = (t == ign_t);
      if (t == ign_t) begin
        base_a = '0;
        last_a = AW'($urandom);
      end
      full = (t >= fs && t < fs + fl) || (int'($urandom_range(99)) < pct);
      if (t == rst_t) begin
        #1 rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        check_eq("midrst_pushes", dut_pushes, 1);
        repeat (2) begin
          @(negedge clk);
          #1;
          check_eq("midrst_hold_wr", wr, 0);
          check_eq("midrst_hold_cs", cs, 1);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; full = 1'b0;
        done_t = -1;
        break;
      end
      #1;
      ea = b + AW'(k);
      exp_w = (k < n) && (t >= ready) && !full;
      if (wr) dut_pushes++;
      check_eq("write", wr, exp_w);
      check_eq("cs", cs, !((k < n) && (t == ready - 2)));
      check_eq("we", we, 1);
      check_eq("busy", busy, t <= done_t);
      check_eq("finish", fin, t == done_t);
      if (k < n) check_eq("addr", addr, ea);
      if (exp_w) begin
        check_eq("data", din, memf(ea));
        k++;
        ready = t + 4;
        if (k == n) done_t = t + 1;
      end
      t++;
    end
    start = 1'b0;
    done_o = done_t;
  endtask

  initial begin
    int d, len, pct, ign;
    logic [AW-1:0] b;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    run_dump(13'h010, 13'h013, 0, -1, 0, -1, -1, d);
    check_eq("basic_done_cycle", d, 16);
    run_dump(13'h010, 13'h013, 0, 7, 5, -1, -1, d);
    check_eq("bp_done_cycle", d, 21);
    run_dump(13'h1FFE, 13'h0001, 0, -1, 0, -1, -1, d);
    check_eq("wrap_done_cycle", d, 16);
    run_dump(13'h0ABC, 13'h0ABC, 0, -1, 0, 2, -1, d);
    check_eq("single_done_cycle", d, 4);
    run_dump(13'h0100, 13'h0107, 0, -1, 0, -1, 5, d);
    run_dump(13'h0100, 13'h0107, 0, -1, 0, -1, -1, d);
    check_eq("post_rst_done_cycle", d, 32);

    key  = $urandom;
    mulc = $urandom | 32'd1;
    for (int i = 0; i < 25; i++) begin
      b   = AW'($urandom);
      len = int'($urandom_range(12, 1));
      pct = int'($urandom_range(40, 0));
      ign = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4 * len - 1, 0)) : -1;
      run_dump(b, b + AW'(len - 1), pct, -1, 0, ign, -1, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/sram_dump_ctrl.md
# sram_dump_ctrl

Readback engine for the data SRAM. On a start pulse it reads a contiguous address range from the SRAM, one word at a time, and pushes each word into an outbound FIFO, which feeds the host/UART dump path. It is the read-side counterpart of the FIFO-to-SRAM init loader. It drives the same active-low SRAM chip-select and write-enable signals, with write-enable held inactive.

## Interface
Parameters:
- ADDRESS_WIDTH, 13, SRAM address width
- DATA_WIDTH, 32, SRAM/FIFO word width

Ports:
- control_mem_clk_i  in  1  clock
- control_mem_rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse, begin dump; ignored unless idle
- base_addr_i  in  ADDRESS_WIDTH  first address, sampled on accepted start
- last_addr_i  in  ADDRESS_WIDTH  last address (inclusive), sampled on accepted start
- sram_dataout_i  in  DATA_WIDTH  SRAM read data, valid the cycle after cs low
- fifo_full_i  in  1  outbound FIFO full
- sram_address_o  out  ADDRESS_WIDTH  SRAM address (registered)
- sram_cs_o  out  1  SRAM chip select, active-low
- sram_we_o  out  1  SRAM write enable, active-low; constant 1
- fifo_datain_o  out  DATA_WIDTH  word to FIFO (registered)
- write_fifo_o  out  1  FIFO push strobe
- busy_o  out  1  dump in progress
- flag_readfinish_o  out  1  one-cycle pulse, dump complete

## Operation
- FSM states: IDLE, SETUP, READ, CAPTURE, PUSH, DONE.
- IDLE:
  - busy_o=0, sram_cs_o=1.
  - start_i=1: latch addr_q<=base_addr_i, last_q<=last_addr_i, go SETUP.
- SETUP: sram_address_o=addr_q, sram_cs_o=1; go READ.
- READ: sram_cs_o=0 for exactly one cycle; go CAPTURE.
- CAPTURE: sram_cs_o=1; register sram_dataout_i into fifo_datain_o at the cycle end; go PUSH.
- PUSH:
  - write_fifo_o = !fifo_full_i (combinational from state and full).
  - While full: hold PUSH with data stable.
  - When not full: the push occurs. If addr_q==last_q, go DONE. Otherwise addr_q<=addr_q+1 (modulo 2^ADDRESS_WIDTH) and go SETUP.
- DONE: flag_readfinish_o=1 for one cycle, busy_o still 1; go IDLE.
- Word count = ((last_q-base) mod 2^ADDRESS_WIDTH)+1.
  - last<base wraps through the top address to 0.
  - base==last dumps exactly one word.
- start_i while not IDLE: ignored; latched range unchanged.
- sram_we_o is never driven 0.
- Reset values (async, any state, including mid-dump):
  - state IDLE
  - sram_address_o=0, sram_cs_o=1, sram_we_o=1
  - fifo_datain_o=0, write_fifo_o=0
  - busy_o=0, flag_readfinish_o=0
  - addr_q=0, last_q=0
- A word pushed before reset stays in the FIFO. An aborted word is not pushed.

## Timing
- Start accepted at edge E0:
  - E0..E1: SETUP, busy_o=1, address valid.
  - E1..E2: READ, cs low.
  - E2..E3: CAPTURE.
  - E3 onward: PUSH.
- Minimum 4 cycles per word; N words take 4N+1 cycles from start to the DONE cycle inclusive.
- Address is stable from SETUP through CAPTURE. It changes only at the PUSH exit edge.
- write_fifo_o is high for exactly one cycle per word. fifo_datain_o is valid whenever write_fifo_o=1.
- Backpressure adds one cycle per full cycle in PUSH. No word is ever dropped or duplicated.
- fifo_full_i deasserting in the same cycle as PUSH entry: push occurs that cycle.

## Test plan
- Basic dump: SRAM model holds mem[a]=a^32'hA5A5_0000, base=0x010, last=0x013, FIFO never full.
  - Expect 4 pushes of 0xA5A5_0010..0xA5A5_0013, in order, 4 cycles apart.
  - Expect flag_readfinish_o 1 cycle after the last push; busy_o low thereafter.
- Backpressure: same range, fifo_full_i high for 5 cycles during the 2nd PUSH.
  - Expect write_fifo_o low during those 5 cycles, data held stable.
  - Expect the push on the first not-full cycle, 4 total words, total latency +5.
- Wrap-around: base=0x1FFE, last=0x0001.
  - Expect addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001, i.e. 4 words, then finish.
- Single word and ignored start: base=last=0x0ABC.
  - Expect 1 push then finish.
  - A second start_i with base=0x0000 during that dump is ignored: no extra words, address never 0x0000.
- Reset mid-dump: assert rst during the READ of word 2 of an 8-word dump.
  - Expect all outputs at reset values immediately, with 1 word pushed total.
  - After release, a new start dumps its full range correctly.
- Invariants checked throughout: sram_we_o always 1; sram_cs_o low only in single-cycle pulses one per word.
